// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a single-port data memory (sync write, combinational
// read) between the core datapath (port 0) and the program/debug loader
// (port 1). One access per cycle, bounded-hold fairness, registered read
// return to the winning port.
module mem_arbiter #(
  parameter int WIDTH    = 8,
  parameter int A_WIDTH  = 10,
  parameter int MAX_HOLD = 4
) (
  input  logic               clk_i,
  input  logic               rst_n,
  input  logic               r0_req_i,
  input  logic               r0_we_i,
  input  logic [A_WIDTH-1:0] r0_addr_i,
  input  logic [WIDTH-1:0]   r0_wdata_i,
  output logic               r0_gnt_o,
  output logic               r0_rvalid_o,
  output logic [WIDTH-1:0]   r0_rdata_o,
  input  logic               r1_req_i,
  input  logic               r1_we_i,
  input  logic [A_WIDTH-1:0] r1_addr_i,
  input  logic [WIDTH-1:0]   r1_wdata_i,
  output logic               r1_gnt_o,
  output logic               r1_rvalid_o,
  output logic [WIDTH-1:0]   r1_rdata_o,
  output logic [A_WIDTH-1:0] mem_addr_o,
  output logic               mem_ce_o,
  output logic [WIDTH-1:0]   mem_wdata_o,
  input  logic [WIDTH-1:0]   mem_rdata_i
);

  localparam int HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] MAX_HOLD_C = HW'(MAX_HOLD);
  localparam logic [HW-1:0] ONE_C      = HW'(1);

  logic          owner_q, owner_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          r0_rvalid_q, r1_rvalid_q;
  logic [WIDTH-1:0] r0_rdata_q, r1_rdata_q;

  logic gnt0_s, gnt1_s, any_gnt_s, win_s, win_we_s;

  // Grant decision: single requester wins outright; on contention the owner
  // keeps the memory until it has used up MAX_HOLD consecutive grants.
  // Grants are forced low while reset is asserted.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (!rst_n) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else if (r0_req_i && r1_req_i) begin
      if (hold_cnt_q < MAX_HOLD_C) begin
        gnt0_s = ~owner_q;
        gnt1_s = owner_q;
      end else begin
        gnt0_s = owner_q;
        gnt1_s = ~owner_q;
      end
    end else begin
      gnt0_s = r0_req_i;
      gnt1_s = r1_req_i;
    end
  end

  assign any_gnt_s = gnt0_s | gnt1_s;
  assign win_s     = gnt1_s;
  assign win_we_s  = gnt1_s ? r1_we_i : r0_we_i;

  // Memory drive: fields of the granted port, all zero when idle.
  always_comb begin
    mem_addr_o  = {A_WIDTH{1'b0}};
    mem_wdata_o = {WIDTH{1'b0}};
    mem_ce_o    = 1'b0;
    if (gnt1_s) begin
      mem_addr_o  = r1_addr_i;
      mem_wdata_o = r1_wdata_i;
      mem_ce_o    = r1_we_i;
    end else if (gnt0_s) begin
      mem_addr_o  = r0_addr_i;
      mem_wdata_o = r0_wdata_i;
      mem_ce_o    = r0_we_i;
    end else begin
      mem_addr_o  = {A_WIDTH{1'b0}};
      mem_wdata_o = {WIDTH{1'b0}};
      mem_ce_o    = 1'b0;
    end
  end

  // Next owner / hold count: saturate on repeat grants, restart at 1 on a
  // hand-over, clear on an idle cycle so a fresh contention starts fair.
  always_comb begin
    owner_d    = owner_q;
    hold_cnt_d = hold_cnt_q;
    if (!any_gnt_s) begin
      hold_cnt_d = {HW{1'b0}};
    end else if (win_s == owner_q) begin
      if (hold_cnt_q < MAX_HOLD_C) begin
        hold_cnt_d = hold_cnt_q + ONE_C;
      end else begin
        hold_cnt_d = MAX_HOLD_C;
      end
    end else begin
      owner_d    = win_s;
      hold_cnt_d = ONE_C;
    end
  end

  // Arbitration state and read-return registers.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      owner_q     <= 1'b0;
      hold_cnt_q  <= {HW{1'b0}};
      r0_rvalid_q <= 1'b0;
      r1_rvalid_q <= 1'b0;
      r0_rdata_q  <= {WIDTH{1'b0}};
      r1_rdata_q  <= {WIDTH{1'b0}};
    end else begin
      owner_q     <= owner_d;
      hold_cnt_q  <= hold_cnt_d;
      r0_rvalid_q <= gnt0_s & ~win_we_s;
      r1_rvalid_q <= gnt1_s & ~win_we_s;
      if (gnt0_s && !win_we_s) begin
        r0_rdata_q <= mem_rdata_i;
      end
      if (gnt1_s && !win_we_s) begin
        r1_rdata_q <= mem_rdata_i;
      end
    end
  end

  assign r0_gnt_o    = gnt0_s;
  assign r1_gnt_o    = gnt1_s;
  assign r0_rvalid_o = r0_rvalid_q;
  assign r1_rvalid_o = r1_rvalid_q;
  assign r0_rdata_o  = r0_rdata_q;
  assign r1_rdata_o  = r1_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small sync-write/comb-read memory.
module tb_mem_arbiter;

  localparam int WIDTH   = 8;
  localparam int A_WIDTH = 10;

  logic               clk_i = 1'b0;
  logic               rst_n;
  logic               r0_req_i, r0_we_i, r1_req_i, r1_we_i;
  logic [A_WIDTH-1:0] r0_addr_i, r1_addr_i;
  logic [WIDTH-1:0]   r0_wdata_i, r1_wdata_i;
  logic               r0_gnt_o, r1_gnt_o, r0_rvalid_o, r1_rvalid_o;
  logic [WIDTH-1:0]   r0_rdata_o, r1_rdata_o;
  logic [A_WIDTH-1:0] mem_addr_o;
  logic               mem_ce_o;
  logic [WIDTH-1:0]   mem_wdata_o, mem_rdata_i;

  logic [WIDTH-1:0] mem_r [0:(1<<A_WIDTH)-1];

  int total = 0;
  int bad   = 0;

  mem_arbiter #(.WIDTH(WIDTH), .A_WIDTH(A_WIDTH), .MAX_HOLD(4)) dut (
    .clk_i(clk_i), .rst_n(rst_n),
    .r0_req_i(r0_req_i), .r0_we_i(r0_we_i), .r0_addr_i(r0_addr_i), .r0_wdata_i(r0_wdata_i),
    .r0_gnt_o(r0_gnt_o), .r0_rvalid_o(r0_rvalid_o), .r0_rdata_o(r0_rdata_o),
    .r1_req_i(r1_req_i), .r1_we_i(r1_we_i), .r1_addr_i(r1_addr_i), .r1_wdata_i(r1_wdata_i),
    .r1_gnt_o(r1_gnt_o), .r1_rvalid_o(r1_rvalid_o), .r1_rdata_o(r1_rdata_o),
    .mem_addr_o(mem_addr_o), .mem_ce_o(mem_ce_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // Memory model: write at posedge, combinational read.
  always_ff @(posedge clk_i) begin
    if (mem_ce_o) mem_r[mem_addr_o] <= mem_wdata_o;
  end
  assign mem_rdata_i = mem_r[mem_addr_o];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic set0(input logic req, input logic we, input logic [A_WIDTH-1:0] a, input logic [WIDTH-1:0] d);
    r0_req_i = req; r0_we_i = we; r0_addr_i = a; r0_wdata_i = d;
  endtask

  task automatic set1(input logic req, input logic we, input logic [A_WIDTH-1:0] a, input logic [WIDTH-1:0] d);
    r1_req_i = req; r1_we_i = we; r1_addr_i = a; r1_wdata_i = d;
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  logic [9:0] seq3;
  logic [4:0] seq5;
  logic [A_WIDTH-1:0] wa [0:3];
  logic [WIDTH-1:0]   wd [0:3];

  initial begin
    seq3 = 10'b0011110000;   // bit i = expected r1_gnt in contention cycle i
    seq5 = 5'b10000;
    wa[0] = 10'h001; wd[0] = 8'h11;
    wa[1] = 10'h002; wd[1] = 8'h22;
    wa[2] = 10'h003; wd[2] = 8'h33;
    wa[3] = 10'h010; wd[3] = 8'h99;

    // 1. Reset with both requesting
    rst_n = 1'b0;
    set0(1'b1, 1'b0, 10'h000, 8'h00);
    set1(1'b1, 1'b0, 10'h000, 8'h00);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check_eq("rst_gnt", {r0_gnt_o, r1_gnt_o}, 2'b00);
    check_eq("rst_ce", mem_ce_o, 1'b0);
    check_eq("rst_rvalid", {r0_rvalid_o, r1_rvalid_o}, 2'b00);
    check_eq("rst_rdata", {r0_rdata_o, r1_rdata_o}, 16'h0000);
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk_i);
    check_eq("rel_gnt", {r0_gnt_o, r1_gnt_o}, 2'b10);
    next_cycle();
    set0(1'b0, 1'b0, 10'h000, 8'h00);
    set1(1'b0, 1'b0, 10'h000, 8'h00);
    next_cycle();
    next_cycle();

    // 2. r1 write then read
    set1(1'b1, 1'b1, 10'h3F2, 8'hA5);
    @(negedge clk_i);
    check_eq("wr_gnt", {r0_gnt_o, r1_gnt_o}, 2'b01);
    check_eq("wr_ce", mem_ce_o, 1'b1);
    check_eq("wr_addr", mem_addr_o, 10'h3F2);
    check_eq("wr_data", mem_wdata_o, 8'hA5);
    next_cycle();
    set1(1'b1, 1'b0, 10'h3F2, 8'h00);
    @(negedge clk_i);
    check_eq("rd_gnt", {r0_gnt_o, r1_gnt_o}, 2'b01);
    check_eq("rd_ce", mem_ce_o, 1'b0);
    next_cycle();
    set1(1'b0, 1'b0, 10'h000, 8'h00);
    check_eq("rd_rvalid1", r1_rvalid_o, 1'b1);
    check_eq("rd_rdata1", r1_rdata_o, 8'hA5);
    check_eq("rd_rvalid0", r0_rvalid_o, 1'b0);
    @(negedge clk_i);
    check_eq("idle_addr", mem_addr_o, 10'h000);
    next_cycle();
    check_eq("rd_pulse", r1_rvalid_o, 1'b0);
    check_eq("rd_hold", r1_rdata_o, 8'hA5);

    // 3. Fairness from a fresh reset
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    set0(1'b1, 1'b0, 10'h100, 8'h00);
    set1(1'b1, 1'b0, 10'h200, 8'h00);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      check_eq($sformatf("fair%0d", i), {r0_gnt_o, r1_gnt_o}, {~seq3[i], seq3[i]});
      next_cycle();
    end
    set0(1'b0, 1'b0, 10'h000, 8'h00);
    set1(1'b0, 1'b0, 10'h000, 8'h00);
    next_cycle();

    // 4. Idle cycle clears hold count
    set0(1'b1, 1'b0, 10'h100, 8'h00);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check_eq($sformatf("solo%0d", i), {r0_gnt_o, r1_gnt_o}, 2'b10);
      next_cycle();
    end
    set0(1'b0, 1'b0, 10'h000, 8'h00);
    next_cycle();
    set0(1'b1, 1'b0, 10'h100, 8'h00);
    set1(1'b1, 1'b0, 10'h200, 8'h00);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      check_eq($sformatf("hold%0d", i), {r0_gnt_o, r1_gnt_o}, {~seq5[i], seq5[i]});
      next_cycle();
    end
    set0(1'b0, 1'b0, 10'h000, 8'h00);
    set1(1'b0, 1'b0, 10'h000, 8'h00);
    next_cycle();

    // 5. Preload then pipelined reads
    for (int i = 0; i < 4; i++) begin
      set0(1'b1, 1'b1, wa[i], wd[i]);
      next_cycle();
    end
    set0(1'b1, 1'b0, 10'h001, 8'h00);
    next_cycle();
    set0(1'b1, 1'b0, 10'h002, 8'h00);
    check_eq("pipe_v1", r0_rvalid_o, 1'b1);
    check_eq("pipe_d1", r0_rdata_o, 8'h11);
    next_cycle();
    set0(1'b1, 1'b0, 10'h003, 8'h00);
    check_eq("pipe_v2", r0_rvalid_o, 1'b1);
    check_eq("pipe_d2", r0_rdata_o, 8'h22);
    next_cycle();
    set0(1'b0, 1'b0, 10'h000, 8'h00);
    check_eq("pipe_v3", r0_rvalid_o, 1'b1);
    check_eq("pipe_d3", r0_rdata_o, 8'h33);
    check_eq("pipe_r1v", r1_rvalid_o, 1'b0);
    next_cycle();
    check_eq("pipe_end", r0_rvalid_o, 1'b0);
    check_eq("pipe_keep", r0_rdata_o, 8'h33);

    // 6. Reset during a write, with a read return in flight
    set0(1'b1, 1'b0, 10'h001, 8'h00);
    next_cycle();
    check_eq("mid_pre_v", r0_rvalid_o, 1'b1);
    rst_n = 1'b0;
    set0(1'b1, 1'b1, 10'h010, 8'h55);
    #1;
    check_eq("mid_v", r0_rvalid_o, 1'b0);
    check_eq("mid_d", r0_rdata_o, 8'h00);
    check_eq("mid_gnt", {r0_gnt_o, r1_gnt_o}, 2'b00);
    check_eq("mid_ce", mem_ce_o, 1'b0);
    next_cycle();
    rst_n = 1'b1;
    set0(1'b1, 1'b0, 10'h010, 8'h00);
    set1(1'b1, 1'b0, 10'h000, 8'h00);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      check_eq($sformatf("post%0d", i), {r0_gnt_o, r1_gnt_o}, {~seq5[i], seq5[i]});
      next_cycle();
    end
    set0(1'b0, 1'b0, 10'h000, 8'h00);
    set1(1'b0, 1'b0, 10'h000, 8'h00);
    check_eq("post_mem", r0_rdata_o, 8'h99);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
